// File: rtl/step_sequencer.sv
// Instruction timestep sequencer: walks T0..T3 per opcode length, in free-run
// or single-step mode, and counts completed instructions.
module step_sequencer (
  input  logic       Clock,
  input  logic       Resetb,
  input  logic       Enter,
  input  logic       Step,
  input  logic [3:0] OPC,
  output logic [1:0] TIME,
  output logic       IRLd,
  output logic       Clr,
  output logic       Busy,
  output logic [7:0] ICNT
);

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T3 = 2'd3;

  logic [1:0] time_q;
  logic [3:0] op_q;
  logic [7:0] icnt_q;
  logic       enter_q;
  logic       rise;
  logic       advance;
  logic [1:0] last_step;

  assign rise = Enter & ~enter_q;

  // ALU opcodes 0010..0111 take three steps; everything else finishes at T1.
  always_comb begin
    last_step = T1;
    if (!op_q[3] && (op_q[2:1] != 2'b00)) begin
      last_step = T3;
    end
  end

  assign advance = Step ? rise : 1'b1;
  assign Clr     = (time_q != T0) && (time_q == last_step);
  assign Busy    = (time_q != T0);
  assign IRLd    = (time_q == T0) && rise;
  assign TIME    = time_q;
  assign ICNT    = icnt_q;

  // enter_q resets high so a key held across reset release needs a fresh press.
  always_ff @(posedge Clock) begin
    if (!Resetb) begin
      time_q  <= T0;
      op_q    <= 4'b0000;
      icnt_q  <= 8'd0;
      enter_q <= 1'b1;
    end else begin
      enter_q <= Enter;
      if (time_q == T0) begin
        if (rise) begin
          op_q   <= OPC;
          time_q <= T1;
        end
      end else if (advance) begin
        if (Clr) begin
          time_q <= T0;
          icnt_q <= icnt_q + 8'd1;
        end else begin
          time_q <= time_q + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Directed, table-driven bench for step_sequencer with hand-computed
// expectations plus reset-priority and 256-instruction wrap sequences.
module tb_step_sequencer;

  logic       Clock;
  logic       Resetb;
  logic       Enter;
  logic       Step;
  logic [3:0] OPC;
  logic [1:0] TIME;
  logic       IRLd;
  logic       Clr;
  logic       Busy;
  logic [7:0] ICNT;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rb;
    logic       en;
    logic       st;
    logic [3:0] opc;
    logic       irld;
    logic [1:0] tm;
    logic       clr;
    logic       busy;
    logic [7:0] icnt;
  } vec_t;

  vec_t vecs[$];

  step_sequencer dut (
    .Clock  (Clock),
    .Resetb (Resetb),
    .Enter  (Enter),
    .Step   (Step),
    .OPC    (OPC),
    .TIME   (TIME),
    .IRLd   (IRLd),
    .Clr    (Clr),
    .Busy   (Busy),
    .ICNT   (ICNT)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic vec_t mk(input logic rb, input logic en, input logic st,
                              input logic [3:0] opc, input logic irld,
                              input logic [1:0] tm, input logic clr,
                              input logic busy, input logic [7:0] icnt);
    vec_t v;
    v.rb = rb; v.en = en; v.st = st; v.opc = opc; v.irld = irld;
    v.tm = tm; v.clr = clr; v.busy = busy; v.icnt = icnt;
    return v;
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act,
                             input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // IRLd is checked before the edge (it is combinational); the rest after.
  task automatic applyStimulus(input vec_t v, input int idx);
    Resetb = v.rb;
    Enter  = v.en;
    Step   = v.st;
    OPC    = v.opc;
    #2;
    checkOutput($sformatf("v%0d_irld", idx), {7'd0, IRLd}, {7'd0, v.irld});
    tick();
    checkOutput($sformatf("v%0d_time", idx), {6'd0, TIME}, {6'd0, v.tm});
    checkOutput($sformatf("v%0d_clr", idx), {7'd0, Clr}, {7'd0, v.clr});
    checkOutput($sformatf("v%0d_busy", idx), {7'd0, Busy}, {7'd0, v.busy});
    checkOutput($sformatf("v%0d_icnt", idx), ICNT, v.icnt);
  endtask

  initial begin
    logic [7:0] icnt_exp;

    //                    rb  en  st  opc      irld tm clr busy icnt
    // key held through reset release, then released
    vecs.push_back(mk(1, 1, 0, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
    // ALU op aborted by reset at T2
    vecs.push_back(mk(1, 1, 0, 4'b0101, 1, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 4'b0101, 0, 2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0101, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
    // free-run ALU op 0010: T1, T2, T3, T0
    vecs.push_back(mk(1, 1, 0, 4'b0010, 1, 1, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 4'b0010, 0, 2, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 4'b0010, 0, 3, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 4'b0010, 0, 0, 0, 0, 1));
    // single-step LD: press, wait, press
    vecs.push_back(mk(1, 0, 1, 4'b0000, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 4'b0000, 1, 1, 1, 1, 1));
    vecs.push_back(mk(1, 0, 1, 4'b0000, 0, 1, 1, 1, 1));
    vecs.push_back(mk(1, 1, 1, 4'b0000, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, 0, 1, 4'b0000, 0, 0, 0, 0, 2));
    // single-step ALU op 0011 with OPC changed mid-instruction
    vecs.push_back(mk(1, 1, 1, 4'b0011, 1, 1, 0, 1, 2));
    vecs.push_back(mk(1, 0, 1, 4'b0000, 0, 1, 0, 1, 2));
    vecs.push_back(mk(1, 1, 1, 4'b0000, 0, 2, 0, 1, 2));
    vecs.push_back(mk(1, 0, 1, 4'b0000, 0, 2, 0, 1, 2));
    vecs.push_back(mk(1, 1, 1, 4'b0000, 0, 3, 1, 1, 2));
    vecs.push_back(mk(1, 0, 1, 4'b0000, 0, 3, 1, 1, 2));
    // press that ends the instruction must not start another
    vecs.push_back(mk(1, 1, 1, 4'b0000, 0, 0, 0, 0, 3));
    vecs.push_back(mk(1, 0, 0, 4'b0000, 0, 0, 0, 0, 3));

    Resetb = 1'b0;
    Enter  = 1'b1;
    Step   = 1'b0;
    OPC    = 4'b0000;
    tick();
    tick();
    checkOutput("rst_time", {6'd0, TIME}, 8'd0);
    checkOutput("rst_clr", {7'd0, Clr}, 8'd0);
    checkOutput("rst_busy", {7'd0, Busy}, 8'd0);
    checkOutput("rst_irld", {7'd0, IRLd}, 8'd0);
    checkOutput("rst_icnt", ICNT, 8'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
    end

    // reset wins over a rise on the same edge; held key then must not start
    Resetb = 1'b0;
    Enter  = 1'b1;
    Step   = 1'b0;
    tick();
    checkOutput("rprio_time", {6'd0, TIME}, 8'd0);
    checkOutput("rprio_icnt", ICNT, 8'd0);
    Resetb = 1'b1;
    #2;
    checkOutput("rprio_irld", {7'd0, IRLd}, 8'd0);
    tick();
    checkOutput("rprio_busy", {7'd0, Busy}, 8'd0);
    Enter = 1'b0;
    tick();

    // 256 free-run NOPs (1010): each is a single T1 with Clr, ICNT wraps
    icnt_exp = 8'd0;
    OPC = 4'b1010;
    for (int n = 0; n < 256; n++) begin
      Enter = 1'b1;
      #2;
      checkOutput($sformatf("nop%0d_irld", n), {7'd0, IRLd}, 8'd1);
      tick();
      checkOutput($sformatf("nop%0d_time", n), {6'd0, TIME}, 8'd1);
      checkOutput($sformatf("nop%0d_clr", n), {7'd0, Clr}, 8'd1);
      Enter = 1'b0;
      tick();
      icnt_exp = icnt_exp + 8'd1;
      checkOutput($sformatf("nop%0d_t0", n), {6'd0, TIME}, 8'd0);
      checkOutput($sformatf("nop%0d_icnt", n), ICNT, icnt_exp);
    end
    checkOutput("wrap_icnt", ICNT, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 The block SHALL have the port `Clock`, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `Resetb`, input, 1 bit: reset, synchronous and active-low, sampled on the rising edge of `Clock`.
REQ-003 The block SHALL have the port `Enter`, input, 1 bit: debounced key level, active-high; only its rising edge is used.
REQ-004 The block SHALL have the port `Step`, input, 1 bit: 1 = single-step mode, 0 = free-run mode.
REQ-005 The block SHALL have the port `OPC`, input, 4 bits: opcode field of the data word; it is valid whenever an instruction start is accepted.
REQ-006 The block SHALL have the port `TIME`, output, 2 bits: current timestep, T0 to T3.
REQ-007 The block SHALL have the port `IRLd`, output, 1 bit: instruction-register load strobe, a one-cycle pulse.
REQ-008 The block SHALL have the port `Clr`, output, 1 bit: the current timestep is the final step of the instruction.
REQ-009 The block SHALL have the port `Busy`, output, 1 bit: an instruction is in progress (TIME is not T0).
REQ-010 The block SHALL have the port `ICNT`, output, 8 bits: count of completed instructions.

Function
REQ-011 The block SHALL detect the `Enter` rising edge as `rise = Enter & ~Enter_q`, where `Enter_q` is `Enter` registered by one cycle.
REQ-012 While TIME = T0 (idle), the block SHALL hold TIME at T0 until `rise` = 1, regardless of `Step`.
REQ-013 On the cycle where TIME = T0 and `rise` = 1, the block SHALL:
- assert `IRLd` combinationally for that one cycle;
- latch `OPC` into an internal `op_q` at that clock edge;
- set TIME to T1 at that clock edge.
REQ-014 The block SHALL derive the final step `LAST` from `op_q` as follows:
- 0000 (LD) and 0001 (MOV) give T1;
- 0010 to 0111 (ALU ops) give T3;
- 1000 to 1111 (reserved, executed as NOP) give T1.
REQ-015 The block SHALL drive `Clr` = 1 exactly when TIME is not T0 and TIME = `LAST`; `Clr` is a Moore output with no combinational path from `Enter`.
REQ-016 The block SHALL advance TIME from a non-T0 state under these conditions:
- in free-run mode, every clock;
- in single-step mode, only on cycles with `rise` = 1.
REQ-017 On an advance while `Clr` = 0, the block SHALL increment TIME by 1; TIME never exceeds `LAST`.
REQ-018 On an advance while `Clr` = 1, the block SHALL set TIME to T0 and increment ICNT by 1, wrapping from 255 to 0.
REQ-019 The block SHALL drive `Busy` = 1 exactly when TIME is not T0.
REQ-020 The block SHALL ignore `OPC` changes while `Busy` = 1; `op_q` holds for the whole instruction.
REQ-021 The block SHALL treat a `rise` on the same cycle that returns TIME to T0 as consumed by that return; it SHALL NOT also start a new instruction.
REQ-022 The block SHALL drive `IRLd` = 0 whenever TIME is not T0.
REQ-023 The block SHALL ignore any change of `Step` mid-instruction until the next cycle; there is no other effect.
REQ-024 In free-run mode the block SHALL execute a 1-step instruction as T1 for one cycle, then T0; a 3-step instruction as T1, T2, T3, then T0.

Reset
REQ-025 While `Resetb` = 0 at a rising edge of `Clock`, the block SHALL set TIME = T0, `op_q` = 0000, ICNT = 0 and `Enter_q` = 1.
REQ-026 The block SHALL drive `Clr` = 0, `Busy` = 0 and `IRLd` = 0 in the cycle after reset.
REQ-027 The block SHALL reset `Enter_q` to 1 so that a key held through the release of reset does not start an instruction; a fresh press is required.
REQ-028 Reset mid-instruction SHALL abort the instruction: TIME returns to T0, ICNT is not incremented, and `Clr` is not asserted.
REQ-029 Reset SHALL take priority over `rise` on the same edge.

Verification
REQ-030 The bench SHALL cover: reset with `Enter` held at 1, then released, then pressed -> no start before the press; on the press, `IRLd` = 1 for one cycle, then TIME = 1.
REQ-031 The bench SHALL cover: `Step` = 0, `OPC` = 0010, press -> TIME sequence 1, 2, 3, 0 on consecutive cycles; `Clr` = 1 only at T3; ICNT 0 -> 1.
REQ-032 The bench SHALL cover: `Step` = 1, `OPC` = 0000, press then press -> TIME = 1 with `Clr` = 1 after the first press; TIME = 0 with ICNT = 1 after the second press; no `IRLd` on the second press.
REQ-033 The bench SHALL cover: `Step` = 1, `OPC` = 0011, with `OPC` changed to 0000 after the start -> `Clr` still asserted only at T3.
REQ-034 The bench SHALL cover: 256 free-run instructions with `OPC` = 1010 -> each shows T1 with `Clr` = 1; ICNT wraps to 0.
REQ-035 The bench SHALL cover: `Resetb` = 0 at T2 of an ALU instruction -> next cycle TIME = 0, `Clr` = 0, `Busy` = 0, ICNT unchanged.
